debug_cmd_unit: RTL and testbench

Host-to-firmware command path for the single-step debugger. It consumes 32-bit command words that the host writes through a block-throttled pipe-in endpoint into a clock-crossing FIFO; the FIFO is instantiated outside this block and its read side is in the clk domain. Decoded commands drive a clock-enable (step_enable) gating the firmware under debug: halt, free-run, step N cycles, and capture triggers for the debug readback path. Packet framing matches the readback stream: command words are followed by a 0xFFFF_FFFF terminator.

---
 rtl/debug_pkg.sv | 41 ++++
 rtl/debug_step_counter.sv | 42 ++++
 rtl/debug_cmd_unit.sv | 144 ++++++++++++++
 tb/tb_debug_cmd_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the single-step debugger command path and its readback
// stream: command word layout, opcodes, packet terminator and FSM encodings.
package debug_pkg;

  localparam logic [3:0]  SYNC_NIBBLE = 4'hA;
  localparam logic [31:0] TERM_WORD   = 32'hFFFF_FFFF;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_HALT      = 4'd1;
  localparam logic [3:0] OP_RUN       = 4'd2;
  localparam logic [3:0] OP_STEP      = 4'd3;
  localparam logic [3:0] OP_STEP_EXT  = 4'd4;
  localparam logic [3:0] OP_CAPTURE   = 4'd5;
  localparam logic [3:0] OP_CLEAR_ERR = 4'd6;

  typedef struct packed {
    logic [3:0]  sync;
    logic [3:0]  opcode;
    logic [23:0] arg;
  } cmd_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXT_REQ,
    ST_EXT_DATA,
    ST_SKIP,
    ST_SKIP_CHK
  } cmd_state_t;

  // base + addend - dec, clamped to all-ones. Callers only set dec when base is
  // nonzero, so the 33-bit result never underflows.
  function automatic logic [31:0] sat_add_dec(input logic [31:0] base,
                                              input logic [31:0] addend,
                                              input logic        dec);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, addend} - {32'd0, dec};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/debug_step_counter.sv
// Remaining-step counter: saturating add of STEP counts, one decrement per
// halted cycle, held while the target free-runs.
module debug_step_counter
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run_mode,
  input  logic        clear,
  input  logic        add_en,
  input  logic [31:0] add_val,
  output logic [31:0] steps_left,
  output logic        steps_next_nz
);

  logic [31:0] steps_next;
  logic        dec;

  // NOTE: every signal driven here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    dec        = !run_mode && (steps_left != '0);
    steps_next = steps_left;
    if (clear) begin
      steps_next = '0;
    end else begin
      steps_next = sat_add_dec(steps_left, add_en ? add_val : 32'd0, dec);
    end
    steps_next_nz = (steps_next != '0);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      steps_left <= '0;
    end else begin
      steps_left <= steps_next;
    end
  end

endmodule

// File: rtl/debug_cmd_unit.sv
// Host command decoder for the single-step debugger: pulls words from the
// command FIFO, decodes them and drives the target clock-enable.
module debug_cmd_unit
  import debug_pkg::*;
#(
  parameter bit START_HALTED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_fifo_q,
  input  logic        cmd_fifo_empty,
  output logic        cmd_fifo_rdreq,
  output logic        step_enable,
  output logic        halted,
  output logic [31:0] steps_left,
  output logic        capture_trigger,
  output logic        cmd_error
);

  cmd_state_t  state, state_next;
  cmd_word_t   word;
  logic        legal_cmd;
  logic        rd_req;
  logic        run_mode, run_mode_next;
  logic        run_set, run_clr, steps_clr;
  logic        add_en;
  logic [31:0] add_val;
  logic        capture_set, err_set, err_clr;
  logic        steps_next_nz;

  assign word      = cmd_fifo_q;
  assign legal_cmd = (word.sync == SYNC_NIBBLE) && (word.opcode <= OP_CLEAR_ERR);

  always_comb begin
    state_next  = state;
    rd_req      = 1'b0;
    run_set     = 1'b0;
    run_clr     = 1'b0;
    steps_clr   = 1'b0;
    add_en      = 1'b0;
    add_val     = '0;
    capture_set = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!cmd_fifo_empty) begin
          rd_req     = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_IDLE;
        if (cmd_fifo_q == TERM_WORD) begin
          state_next = ST_IDLE;
        end else if (!legal_cmd) begin
          err_set    = 1'b1;
          state_next = ST_SKIP;
        end else begin
          case (word.opcode)
            OP_HALT: begin
              run_clr   = 1'b1;
              steps_clr = 1'b1;
            end
            OP_RUN:       run_set     = 1'b1;
            OP_STEP: begin
              add_en  = 1'b1;
              add_val = {8'd0, word.arg};
            end
            OP_STEP_EXT:  state_next  = ST_EXT_REQ;
            OP_CAPTURE:   capture_set = 1'b1;
            OP_CLEAR_ERR: err_clr     = 1'b1;
            default:      ;
          endcase
        end
      end
      ST_EXT_REQ: begin
        if (!cmd_fifo_empty) begin
          rd_req     = 1'b1;
          state_next = ST_EXT_DATA;
        end
      end
      // Any value is a legal count here, including the terminator pattern.
      ST_EXT_DATA: begin
        add_en     = 1'b1;
        add_val    = cmd_fifo_q;
        state_next = ST_IDLE;
      end
      ST_SKIP: begin
        if (!cmd_fifo_empty) begin
          rd_req     = 1'b1;
          state_next = ST_SKIP_CHK;
        end
      end
      ST_SKIP_CHK: begin
        state_next = (cmd_fifo_q == TERM_WORD) ? ST_IDLE : ST_SKIP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A read issued while reset is held would pop a word that the restarted
  // decoder never sees, so the strobe is suppressed during reset.
  assign cmd_fifo_rdreq = rd_req & reset;

  assign run_mode_next = run_clr ? 1'b0 : (run_set ? 1'b1 : run_mode);

  debug_step_counter u_step_counter (
    .clk           (clk),
    .reset         (reset),
    .run_mode      (run_mode),
    .clear         (steps_clr),
    .add_en        (add_en),
    .add_val       (add_val),
    .steps_left    (steps_left),
    .steps_next_nz (steps_next_nz)
  );

  // NOTE: only control state is reset; there is no storage array here whose
  // contents would need clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      run_mode        <= ~START_HALTED;
      step_enable     <= ~START_HALTED;
      halted          <= START_HALTED;
      capture_trigger <= 1'b0;
      cmd_error       <= 1'b0;
    end else begin
      state           <= state_next;
      run_mode        <= run_mode_next;
      step_enable     <= run_mode_next | steps_next_nz;
      halted          <= ~(run_mode_next | steps_next_nz);
      capture_trigger <= capture_set;
      if (err_set) begin
        cmd_error <= 1'b1;
      end else if (err_clr) begin
        cmd_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_cmd_unit.sv
// Directed bench for debug_cmd_unit: a behavioural show-behind FIFO feeds
// command packets, and outputs are compared on the falling clock edge.
module tb_debug_cmd_unit;

  localparam logic [31:0] TERM = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic [31:0] cmd_fifo_q;
  logic        cmd_fifo_empty;
  logic        cmd_fifo_rdreq;
  logic        step_enable;
  logic        halted;
  logic [31:0] steps_left;
  logic        capture_trigger;
  logic        cmd_error;

  logic [31:0] fifo[$];
  int          n_cmp;
  int          n_err;
  int          rd_total;
  int          viol;
  logic        rd_prev;

  debug_cmd_unit dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_fifo_q      (cmd_fifo_q),
    .cmd_fifo_empty  (cmd_fifo_empty),
    .cmd_fifo_rdreq  (cmd_fifo_rdreq),
    .step_enable     (step_enable),
    .halted          (halted),
    .steps_left      (steps_left),
    .capture_trigger (capture_trigger),
    .cmd_error       (cmd_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    cmd_fifo_empty = 1'b0;
  endtask

  // Advances n cycles from one falling edge to the next, modelling the FIFO
  // read port and checking the strobe protocol just before each rising edge.
  task automatic tick(input int n = 1);
    logic rd_s;
    for (int i = 0; i < n; i++) begin
      #4;
      rd_s = cmd_fifo_rdreq;
      if (rd_s) begin
        rd_total++;
        if (cmd_fifo_empty) viol++;
        if (rd_prev) viol++;
      end
      rd_prev = rd_s;
      @(posedge clk);
      #1;
      if (rd_s && fifo.size() > 0) cmd_fifo_q = fifo.pop_front();
      cmd_fifo_empty = (fifo.size() == 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int rd0;
    logic [31:0] exp_steps [6] = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    n_cmp = 0; n_err = 0; rd_total = 0; viol = 0; rd_prev = 1'b0;
    reset = 1'b0;
    cmd_fifo_q = '0;
    cmd_fifo_empty = 1'b1;
    @(negedge clk);
    tick(3);
    reset = 1'b1;

    // Reset state, halted start, idle FIFO
    chk("rst_step_enable", step_enable, 0);
    chk("rst_halted", halted, 1);
    chk("rst_steps_left", steps_left, 0);
    chk("rst_capture", capture_trigger, 0);
    chk("rst_cmd_error", cmd_error, 0);
    chk("rst_rdreq", cmd_fifo_rdreq, 0);
    rd0 = rd_total;
    tick(100);
    chk("idle_rdreq_count", rd_total - rd0, 0);
    chk("idle_step_enable", step_enable, 0);

    // STEP 5 followed by terminator
    push(32'hA300_0005);
    push(TERM);
    tick();
    chk("step5_decode_steps", steps_left, 0);
    chk("step5_decode_en", step_enable, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("step5_steps_%0d", i), steps_left, exp_steps[i]);
      chk($sformatf("step5_en_%0d", i), step_enable, (i < 5) ? 1 : 0);
      chk($sformatf("step5_halted_%0d", i), halted, (i < 5) ? 0 : 1);
    end
    chk("step5_fifo_drained", fifo.size(), 0);

    // STEP 10 then STEP_EXT with all-ones count saturates
    push(32'hA300_000A);
    push(32'hA400_0000);
    push(TERM);
    tick(2);
    chk("ext_steps_10", steps_left, 32'd10);
    tick(3);
    chk("ext_steps_7", steps_left, 32'd7);
    tick();
    chk("ext_saturated", steps_left, 32'hFFFF_FFFF);
    chk("ext_en", step_enable, 1);
    tick();
    chk("ext_sat_dec", steps_left, 32'hFFFF_FFFE);
    push(32'hA100_0000);
    tick();
    chk("halt_decode_en", step_enable, 1);
    tick();
    chk("halt_steps", steps_left, 0);
    chk("halt_en", step_enable, 0);
    chk("halt_halted", halted, 1);

    // Bad sync: skip to terminator, then RUN
    push(32'hB200_0000);
    push(32'hA200_0000);
    push(TERM);
    push(32'hA200_0000);
    tick(2);
    chk("badsync_error", cmd_error, 1);
    chk("badsync_en_k2", step_enable, 0);
    tick(5);
    chk("skipped_run_en", step_enable, 0);
    tick();
    chk("run_en", step_enable, 1);
    chk("run_halted", halted, 0);
    chk("run_error_sticky", cmd_error, 1);
    tick(10);
    chk("run_en_hold", step_enable, 1);
    chk("run_error_hold", cmd_error, 1);

    // STEP under RUN is held, not decremented
    push(32'hA300_0003);
    tick(2);
    chk("run_step_add", steps_left, 32'd3);
    tick(2);
    chk("run_step_held", steps_left, 32'd3);
    chk("run_step_en", step_enable, 1);
    push(32'hA600_0000);
    tick();
    chk("clr_decode_error", cmd_error, 1);
    tick();
    chk("clr_error", cmd_error, 0);

    // Illegal opcode with valid sync
    push(32'hA700_0000);
    push(TERM);
    tick(2);
    chk("illegal_op_error", cmd_error, 1);
    tick(2);
    push(32'hA600_0000);
    tick(2);
    chk("clr_error_2", cmd_error, 0);
    chk("clr_en", step_enable, 1);
    push(32'hA100_0000);
    tick();
    chk("run_halt_decode_steps", steps_left, 32'd3);
    tick();
    chk("run_halt_steps", steps_left, 0);
    chk("run_halt_en", step_enable, 0);

    // CAPTURE pulse is exactly one cycle
    push(32'hA500_0000);
    tick();
    chk("cap_decode", capture_trigger, 0);
    tick();
    chk("cap_pulse", capture_trigger, 1);
    tick();
    chk("cap_end", capture_trigger, 0);

    // Set an error, then reset in the middle of STEP_EXT
    push(32'hF000_0000);
    push(TERM);
    tick(2);
    chk("pre_rst_error", cmd_error, 1);
    tick(2);
    push(32'hA200_0000);
    push(32'hA300_0004);
    push(32'hA400_0000);
    tick(6);
    chk("pre_rst_steps", steps_left, 32'd4);
    chk("pre_rst_en", step_enable, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_steps", steps_left, 0);
    chk("midrst_en", step_enable, 0);
    chk("midrst_halted", halted, 1);
    chk("midrst_error", cmd_error, 0);
    chk("midrst_capture", capture_trigger, 0);
    chk("midrst_rdreq", cmd_fifo_rdreq, 0);
    push(32'hA300_0002);
    tick(2);
    chk("post_rst_header_steps", steps_left, 32'd2);
    chk("post_rst_header_en", step_enable, 1);
    tick(2);
    chk("post_rst_done_steps", steps_left, 0);
    chk("post_rst_done_en", step_enable, 0);

    chk("rdreq_protocol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
